// File: rtl/wb_ram_arbiter_pkg.sv
// Shared types and constants for the Wishbone block-RAM arbiter.
// FSM encoding and watchdog width live here.
package wb_ram_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int WDOG_W = 8;

endpackage

// File: rtl/wb_ram_arbiter_rr_pick.sv
// Round-robin picker: searches upward from last+1, wrapping to 0.
// Returns a one-hot grant and its binary index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   c;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one block-RAM port.
// Owner keeps the bus while its cyc stays high; watchdog ends hung strobes.
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_ni,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*32-1:0]         m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]           m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [SEL_WIDTH-1:0]            s_sel_o,
  output logic [31:0]                     s_adr_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  state_t                 state_q, state_d;
  logic [IW-1:0]          owner_q, last_q, pick_idx;
  logic [NUM_MASTERS-1:0] grant_q, req, pick_grant;
  logic [WDOG_W-1:0]      wdog_q;
  logic                   owned, own_cyc, own_stb, timeout;
  int                     own;

  assign req = m_cyc_i & m_stb_i;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign owned   = (state_q == OWNED);
  assign own     = int'(owner_q);
  assign own_cyc = owned & m_cyc_i[own];
  assign own_stb = own_cyc & m_stb_i[own];
  // Ack in the expiry cycle wins over the error.
  assign timeout = own_stb & ~s_ack_i &
                   (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

  always_comb begin
    state_d = state_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) state_d = OWNED;
      end
      OWNED: begin
        if (!own_cyc) state_d = IDLE;
        s_cyc_o      = own_cyc;
        s_stb_o      = own_stb & ~timeout;
        s_we_o       = own_cyc & m_we_i[own];
        s_sel_o      = m_sel_i[own*SEL_WIDTH +: SEL_WIDTH];
        s_adr_o      = m_adr_i[own*32 +: 32];
        s_dat_o      = m_dat_i[own*DATA_WIDTH +: DATA_WIDTH];
        m_ack_o[own] = own_stb & s_ack_i;
        m_err_o[own] = timeout;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      wdog_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= pick_idx;
            grant_q <= pick_grant;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            last_q  <= owner_q;
            grant_q <= '0;
          end
        end
      endcase
      if (!own_cyc || s_ack_i || timeout) begin
        wdog_q <= '0;
      end else if (own_stb) begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: 2-master instance plus a
// 3-master instance for round-robin rotation.
module tb_wb_ram_arbiter;

  typedef struct {
    byte         k;
    int          m;
    logic [15:0] d;
    bit          cd;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // 2-master DUT
  logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [3:0]  m_sel = '0;
  logic [63:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic [15:0] m_rdat;
  logic [1:0]  m_ack, m_err, grant;
  logic        s_cyc, s_stb, s_we;
  logic [1:0]  s_sel;
  logic [31:0] s_adr;
  logic [15:0] s_wdat;
  logic [15:0] ram_rdat = '0;
  logic        ram_ack = 1'b0;
  logic        mute = 1'b0;
  logic        force_ack = 1'b0;
  logic [15:0] mem [256];

  wb_ram_arbiter dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_sel_i   (m_sel),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_dat_o   (m_rdat),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_wdat),
    .s_dat_i   (ram_rdat),
    .s_ack_i   (ram_ack),
    .grant_o   (grant)
  );

  always @(posedge clk) begin
    if ((s_cyc && s_stb && !ram_ack && !mute) || force_ack) begin
      ram_ack  <= 1'b1;
      ram_rdat <= mem[s_adr[7:0]];
      if (s_we) mem[s_adr[7:0]] <= s_wdat;
    end else begin
      ram_ack <= 1'b0;
    end
  end

  // 3-master DUT
  logic [2:0]  c_cyc = '0, c_stb = '0;
  logic [2:0]  c_ack, c_err, grant3;
  logic [15:0] c_rdat;
  logic        s3_cyc, s3_stb, s3_we;
  logic [1:0]  s3_sel;
  logic [31:0] s3_adr;
  logic [15:0] s3_wdat;
  logic        ack3 = 1'b0;
  logic        run3 = 1'b0;

  wb_ram_arbiter #(.NUM_MASTERS(3)) dut3 (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m_cyc_i   (c_cyc),
    .m_stb_i   (c_stb),
    .m_we_i    (3'b000),
    .m_sel_i   (6'b111111),
    .m_adr_i   (96'h0),
    .m_dat_i   (48'h0),
    .m_dat_o   (c_rdat),
    .m_ack_o   (c_ack),
    .m_err_o   (c_err),
    .s_cyc_o   (s3_cyc),
    .s_stb_o   (s3_stb),
    .s_we_o    (s3_we),
    .s_sel_o   (s3_sel),
    .s_adr_o   (s3_adr),
    .s_dat_o   (s3_wdat),
    .s_dat_i   (16'h5A5A),
    .s_ack_i   (ack3),
    .grant_o   (grant3)
  );

  always @(posedge clk) ack3 <= s3_cyc & s3_stb & ~ack3;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_assert++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic int oh2i(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Scoreboard
  ev_t sbq[$];

  function automatic void expect_ev(input byte k, input int m,
                                    input logic [15:0] d, input bit cd);
    ev_t e;
    e.k = k; e.m = m; e.d = d; e.cd = cd;
    sbq.push_back(e);
  endfunction

  task automatic sb_pop(input byte k, input int m, input logic [15:0] d);
    ev_t e;
    n_assert++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got %c m%0d d=%h, expected none",
               k, m, d);
    end else begin
      e = sbq.pop_front();
      if (e.k != k || e.m != m || (e.cd && e.d !== d)) begin
        n_fail++;
        $display("FAIL sb_event: got %c m%0d d=%h, expected %c m%0d d=%h",
                 k, m, d, e.k, e.m, e.d);
      end
    end
  endtask

  logic [1:0] prev_g = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_g == 2'b00 && grant != 2'b00)
        sb_pop("G", oh2i({1'b0, grant}), 16'h0);
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i]) sb_pop("A", i, m_rdat);
        if (m_err[i]) sb_pop("E", i, 16'h0);
      end
    end
    prev_g <= grant;
  end

  // Rotation monitor for the 3-master instance
  int q3[$];
  int gap3 = 0;
  int seen3 = 0;
  logic [2:0] prev3 = '0;
  always @(negedge clk) begin
    if (prev3 == 3'b000 && grant3 != 3'b000) begin
      if (q3.size() > 0) begin
        chk("rr3_order", oh2i(grant3), q3.pop_front());
        if (seen3 > 0) chk("rr3_gap", gap3, 1);
        seen3++;
      end
      gap3 = 0;
    end else if (grant3 == 3'b000) begin
      gap3++;
    end
    prev3 <= grant3;
  end

  task automatic master_xfer(input int i, input bit we,
                             input logic [31:0] adr, input logic [15:0] dat,
                             input int force_at,
                             output int n, output bit got_err);
    bit done;
    done = 1'b0;
    got_err = 1'b0;
    n = 0;
    m_adr[i*32 +: 32] = adr;
    m_dat[i*16 +: 16] = dat;
    m_sel[i*2 +: 2]   = 2'b11;
    m_we[i]  = we;
    m_cyc[i] = 1'b1;
    m_stb[i] = 1'b1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (force_at != 0) force_ack = (n == force_at);
      if (m_ack[i] || m_err[i]) begin
        done = 1'b1;
        got_err = m_err[i];
        if (m_err[i]) chk("stb_gated_on_err", {31'h0, s_stb}, 0);
      end
    end
    if (!done) bound_fail("xfer_wait");
    @(posedge clk);
    #1;
    m_stb[i] = 1'b0;
    m_cyc[i] = 1'b0;
    m_we[i]  = 1'b0;
  endtask

  task automatic lock3_writes();
    int  n;
    bit  done;
    logic [31:0] a;
    m_cyc[1] = 1'b1;
    m_we[1]  = 1'b1;
    m_sel[3:2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      a = 32'h20 + k;
      m_adr[63:32] = a;
      m_dat[31:16] = (k == 0) ? 16'h1111 : (k == 1) ? 16'h2222 : 16'h3333;
      m_stb[1] = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
        if (grant[1] && s_cyc) chk("lock_adr", s_adr, a);
        if (m_ack[1]) done = 1'b1;
      end
      if (!done) bound_fail("lock_wait");
      @(posedge clk);
      #1;
    end
    m_stb[1] = 1'b0;
    m_cyc[1] = 1'b0;
    m_we[1]  = 1'b0;
  endtask

  task automatic m3_loop(input int i);
    int n;
    while (run3) begin
      c_cyc[i] = 1'b1;
      c_stb[i] = 1'b1;
      n = 0;
      while (run3 && !c_ack[i] && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (run3 && n >= 30) bound_fail("m3_wait");
      @(posedge clk);
      #1;
      c_cyc[i] = 1'b0;
      c_stb[i] = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded limit");
    $fatal(1);
  end

  initial begin
    int n0, n1;
    bit e0, e1;
    for (int a = 0; a < 256; a++) mem[a] = 16'hA000 + 16'(a);

    repeat (3) @(posedge clk);
    chk("rst_grant", {30'h0, grant}, 0);
    chk("rst_s_cyc", {31'h0, s_cyc}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", {30'h0, grant}, 0);
    chk("post_rst_ack", {30'h0, m_ack | m_err}, 0);
    chk("post_rst_s_stb", {31'h0, s_stb}, 0);

    // Contention after reset: master 0 first, then master 1
    @(posedge clk); #1;
    expect_ev("G", 0, 16'h0, 0);
    expect_ev("A", 0, 16'hA010, 1);
    expect_ev("G", 1, 16'h0, 0);
    expect_ev("A", 1, 16'hA010, 1);
    fork
      master_xfer(0, 1'b0, 32'h10, 16'h0, 0, n0, e0);
      master_xfer(1, 1'b0, 32'h10, 16'h0, 0, n1, e1);
    join
    chk("first_ack_latency", n0, 3);

    // Bus lock: master 1 writes three words while master 0 waits
    repeat (2) @(posedge clk); #1;
    expect_ev("G", 1, 16'h0, 0);
    expect_ev("A", 1, 16'h0, 0);
    expect_ev("A", 1, 16'h0, 0);
    expect_ev("A", 1, 16'h0, 0);
    expect_ev("G", 0, 16'h0, 0);
    expect_ev("A", 0, 16'h3333, 1);
    fork
      lock3_writes();
      begin
        repeat (3) @(negedge clk);
        master_xfer(0, 1'b0, 32'h22, 16'h0, 0, n0, e0);
      end
    join

    // Watchdog: no ack ever, then ack in the expiry cycle
    mute = 1'b1;
    repeat (2) @(posedge clk); #1;
    expect_ev("G", 0, 16'h0, 0);
    expect_ev("E", 0, 16'h0, 0);
    master_xfer(0, 1'b0, 32'h30, 16'h0, 0, n0, e0);
    chk("timeout_err", {31'h0, e0}, 1);
    chk("timeout_cycle", n0, 17);

    repeat (2) @(posedge clk); #1;
    expect_ev("G", 0, 16'h0, 0);
    expect_ev("A", 0, 16'hA031, 1);
    master_xfer(0, 1'b0, 32'h31, 16'h0, 16, n0, e0);
    chk("coincide_no_err", {31'h0, e0}, 0);
    chk("coincide_cycle", n0, 17);

    // Reset in the middle of a pending read
    repeat (2) @(posedge clk); #1;
    expect_ev("G", 1, 16'h0, 0);
    m_adr[63:32] = 32'h12;
    m_sel[3:2] = 2'b11;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_grant", {30'h0, grant}, 0);
    chk("arst_s_cyc", {31'h0, s_cyc}, 0);
    chk("arst_s_stb", {31'h0, s_stb}, 0);
    chk("arst_ack_err", {30'h0, m_ack | m_err}, 0);
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    mute = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    expect_ev("G", 0, 16'h0, 0);
    expect_ev("A", 0, 16'h2222, 1);
    expect_ev("G", 1, 16'h0, 0);
    expect_ev("A", 1, 16'h3333, 1);
    fork
      master_xfer(0, 1'b0, 32'h21, 16'h0, 0, n0, e0);
      master_xfer(1, 1'b0, 32'h22, 16'h0, 0, n1, e1);
    join

    // Three masters requesting continuously
    q3.push_back(0);
    q3.push_back(1);
    q3.push_back(2);
    q3.push_back(0);
    @(posedge clk); #1;
    run3 = 1'b1;
    fork
      m3_loop(0);
      m3_loop(1);
      m3_loop(2);
      begin
        repeat (40) @(posedge clk);
        run3 = 1'b0;
      end
    join

    repeat (4) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("rr3_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 SHALL take parameter NUM_MASTERS, default 2: number of Wishbone requesters sharing one block RAM port.
REQ-002 SHALL take parameter DATA_WIDTH, default 16: bus data width.
REQ-003 SHALL take parameter SEL_WIDTH, default 2: byte-select width, equal to DATA_WIDTH/8.
REQ-004 SHALL take parameter TIMEOUT_CYCLES, default 16: watchdog limit, 2..255.
REQ-005 SHALL have port wb_clk_i  in  1  single clock; one clock; all state on its rising edge.
REQ-006 SHALL have port wb_rst_ni  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS each  per-master cycle, strobe and write-enable; bit i belongs to master i.
REQ-008 SHALL have ports m_sel_i  in  NUM_MASTERS*SEL_WIDTH,  m_adr_i  in  NUM_MASTERS*32,  m_dat_i  in  NUM_MASTERS*DATA_WIDTH; slice i belongs to master i.
REQ-009 SHALL have port m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
REQ-010 SHALL have ports m_ack_o, m_err_o  out  NUM_MASTERS each  per-master acknowledge and timeout error.
REQ-011 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1;  s_sel_o  out  SEL_WIDTH;  s_adr_o  out  32;  s_dat_o  out  DATA_WIDTH: RAM-side request.
REQ-012 SHALL have ports s_dat_i  in  DATA_WIDTH  and  s_ack_i  in  1: RAM-side response.
REQ-013 SHALL have port grant_o  out  NUM_MASTERS: one-hot current owner, all zero when idle.

Function
REQ-014 SHALL use a two-state FSM: IDLE and OWNED.
REQ-015 In IDLE, when any m_cyc_i[i] and m_stb_i[i] are both high, the FSM SHALL move to OWNED on the next edge, granting the requester that follows last_grant in round-robin order (last_grant+1, wrapping NUM_MASTERS-1 to 0).
REQ-016 Arbitration latency SHALL be exactly one cycle: the request is seen in IDLE at edge N, and grant_o is valid after edge N.
REQ-017 In OWNED, the owner's cyc/stb/we/sel/adr/dat SHALL pass to the s_* outputs combinationally, and s_ack_i SHALL pass to m_ack_o of the owner only.
REQ-018 Non-owner m_ack_o and m_err_o SHALL be 0 at all times; s_cyc_o and s_stb_o SHALL be 0 in IDLE.
REQ-019 The owner SHALL keep the bus across any number of transfers while its m_cyc_i stays high (bus lock).
REQ-020 When the owner drops m_cyc_i, the FSM SHALL return to IDLE on that edge and last_grant SHALL take the owner index; this leaves one dead cycle between tenures.
REQ-021 Requests from other masters that arrive during OWNED SHALL wait and SHALL NOT be lost; m_ack_o stays 0 for them.
REQ-022 The watchdog counter SHALL increment each OWNED cycle in which the owner's stb is high and s_ack_i is low, and SHALL clear on s_ack_i or on leaving OWNED.
REQ-023 When the counter equals TIMEOUT_CYCLES-1 with no ack, m_err_o of the owner SHALL pulse for one cycle, s_stb_o SHALL be forced to 0 in that cycle, and the counter SHALL clear; ownership is kept.
REQ-024 If s_ack_i and the timeout coincide, ack SHALL win and no error SHALL be raised.
REQ-025 A master that drops m_cyc_i while its single-cycle request is pending SHALL lose the transfer and SHALL receive no ack.

Reset
REQ-026 Assertion of wb_rst_ni low SHALL immediately force: state IDLE, grant_o 0, last_grant NUM_MASTERS-1 (so master 0 wins first), watchdog 0, all s_* outputs and m_ack_o/m_err_o 0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack or error; deassertion SHALL be synchronised by the instantiating level.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=0, OWNED=1) and the watchdog counter width constant (8).
REQ-029 The round-robin priority pick SHALL be a sub-module rr_pick (request vector plus last index in, one-hot grant plus index out).

Verification
REQ-030 After reset, masters 0 and 1 both request a read at adr 0x10 in the same cycle -> grant_o=01 one cycle later; m_ack_o[0] follows s_ack_i; master 1 gets grant_o=10 after the dead cycle.
REQ-031 Master 1 holds cyc for 3 writes while master 0 requests -> master 0 sees no ack until master 1 drops cyc; s_adr_o shows only master-1 addresses meanwhile.
REQ-032 RAM model never acks, TIMEOUT_CYCLES=16 -> m_err_o of the owner pulses once 16 cycles after stb, s_stb_o is 0 in that cycle; ack arriving in the same cycle -> ack only, no error.
REQ-033 wb_rst_ni pulsed low mid-read -> all outputs 0 asynchronously; the next contention grants master 0.
REQ-034 NUM_MASTERS=3, all request continuously -> grant order 0,1,2,0 with one idle cycle between tenures.
